framebuffer_arbiter: RTL and testbench

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

---
 rtl/fb_arb_pkg.sv | 14 +
 rtl/fb_wr_fifo.sv | 55 +++++
 rtl/framebuffer_arbiter.sv | 102 ++++++++++
 tb/tb_framebuffer_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arb_pkg.sv
// rtl/fb_arb_pkg.sv - shared widths and grant encoding for the framebuffer arbiter
package fb_arb_pkg;

  localparam int ADDR_W_DEF = 14;
  localparam int DATA_W_DEF = 16;
  localparam logic [3:0] SPRAM_MASK_ALL = 4'b1111;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_RD,
    GNT_WR
  } gnt_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - two-entry write buffer holding {addr, data} words from the camera
module fb_wr_fifo #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Concurrent push and pop leaves occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/framebuffer_arbiter.sv
// rtl/framebuffer_arbiter.sv - single-port SPRAM arbiter between camera writes and VGA reads
module framebuffer_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_RD_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] spram_addr,
  output logic [DATA_W-1:0] spram_datain,
  output logic              spram_wren,
  output logic [3:0]        spram_maskwren,
  output logic              spram_cs,
  input  logic [DATA_W-1:0] spram_dataout
);

  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(MAX_RD_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_RD_BURST);

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CNT_W-1:0]  rd_burst_cnt;
  logic              burst_at_max;
  gnt_e              gnt;

  assign wr_ready  = !reset && !fifo_full;
  assign fifo_push = wr_req && wr_ready;
  assign fifo_pop  = (gnt == GNT_WR);
  assign {head_addr, head_data} = fifo_head;

  fb_wr_fifo #(
    .W(ENT_W)
  ) u_wr_fifo (
    .clk  (clk),
    .reset(reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  ({wr_addr, wr_data}),
    .dout (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign burst_at_max = (rd_burst_cnt == BURST_MAX);

  // Reads win unless a pending write has already waited out a full read burst
  always_comb begin
    gnt = GNT_NONE;
    if (!reset) begin
      if (!fifo_empty && (!rd_req || burst_at_max)) begin
        gnt = GNT_WR;
      end else if (rd_req) begin
        gnt = GNT_RD;
      end
    end
  end

  assign spram_cs       = (gnt != GNT_NONE);
  assign spram_wren     = (gnt == GNT_WR);
  assign spram_addr     = (gnt == GNT_WR) ? head_addr : rd_addr;
  assign spram_datain   = head_data;
  assign spram_maskwren = SPRAM_MASK_ALL;
  assign rd_ready       = (gnt == GNT_RD);
  assign rd_data        = spram_dataout;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_burst_cnt <= '0;
    end else if (gnt == GNT_WR || fifo_empty) begin
      rd_burst_cnt <= '0;
    end else if (gnt == GNT_RD && !burst_at_max) begin
      rd_burst_cnt <= rd_burst_cnt + 1'b1;
    end
  end

  // SPRAM output register lands one cycle after the access
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= (gnt == GNT_RD);
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb/tb_framebuffer_arbiter.sv - directed self-checking bench for framebuffer_arbiter
module tb_framebuffer_arbiter;

  logic        clk;
  logic        reset;
  logic        wr_req;
  logic [13:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic        rd_req;
  logic [13:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic [13:0] spram_addr;
  logic [15:0] spram_datain;
  logic        spram_wren;
  logic [3:0]  spram_maskwren;
  logic        spram_cs;
  logic [15:0] spram_dataout;

  logic [15:0] mem [0:16383];

  int n_cmp = 0;
  int n_bad = 0;

  framebuffer_arbiter #(
    .ADDR_W(14),
    .DATA_W(16),
    .MAX_RD_BURST(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ready      (wr_ready),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ready      (rd_ready),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .spram_addr    (spram_addr),
    .spram_datain  (spram_datain),
    .spram_wren    (spram_wren),
    .spram_maskwren(spram_maskwren),
    .spram_cs      (spram_cs),
    .spram_dataout (spram_dataout)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Behavioural SPRAM with registered read data
  always @(posedge clk) begin
    if (spram_cs) begin
      if (spram_wren) mem[spram_addr] <= spram_datain;
      else spram_dataout <= mem[spram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic req, input logic [13:0] a, input logic [15:0] d);
    wr_req  = req;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    reset = 1'b1;
    set_wr(1'b0, 14'h0, 16'h0);
    rd_req  = 1'b0;
    rd_addr = 14'h0;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_cs", spram_cs, 0);
    chk("rst_wren", spram_wren, 0);
    chk("mask", spram_maskwren, 4'hF);

    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", wr_ready, 1);
    chk("idle_cs", spram_cs, 0);

    // Single write drains the next cycle
    tick();
    set_wr(1'b1, 14'h0010, 16'hBEEF);
    @(negedge clk);
    chk("w1_accept", wr_ready, 1);
    tick();
    set_wr(1'b0, 14'h0, 16'h0);
    @(negedge clk);
    chk("w1_wren", spram_wren, 1);
    chk("w1_cs", spram_cs, 1);
    chk("w1_addr", spram_addr, 14'h0010);
    chk("w1_data", spram_datain, 16'hBEEF);
    tick();
    @(negedge clk);
    chk("w1_empty_cs", spram_cs, 0);

    // Write then read back the same word
    set_wr(1'b1, 14'h0020, 16'h1234);
    tick();
    set_wr(1'b0, 14'h0, 16'h0);
    @(negedge clk);
    chk("w2_addr", spram_addr, 14'h0020);
    tick();
    rd_req  = 1'b1;
    rd_addr = 14'h0020;
    @(negedge clk);
    chk("r2_ready", rd_ready, 1);
    chk("r2_wren", spram_wren, 0);
    chk("r2_addr", spram_addr, 14'h0020);
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("r2_valid", rd_valid, 1);
    chk("r2_data", rd_data, 16'h1234);

    // No forwarding: a read racing a newly accepted write sees the old word
    set_wr(1'b1, 14'h0030, 16'hAAAA);
    tick();
    set_wr(1'b0, 14'h0, 16'h0);
    tick();
    set_wr(1'b1, 14'h0030, 16'h5555);
    rd_req  = 1'b1;
    rd_addr = 14'h0030;
    @(negedge clk);
    chk("fwd_rd_first", rd_ready, 1);
    tick();
    set_wr(1'b0, 14'h0, 16'h0);
    rd_req = 1'b0;
    @(negedge clk);
    chk("fwd_old_data", rd_data, 16'hAAAA);
    chk("fwd_wr_after", spram_wren, 1);
    tick();

    // Continuous reads with one pending write: 4 reads, 1 write, reads resume
    rd_req  = 1'b1;
    rd_addr = 14'h0040;
    set_wr(1'b1, 14'h0050, 16'h0C0C);
    @(negedge clk);
    chk("burst_push_rd", rd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      set_wr(1'b0, 14'h0, 16'h0);
      @(negedge clk);
      chk($sformatf("burst_rd%0d", i), rd_ready, 1);
    end
    tick();
    @(negedge clk);
    chk("burst_wr_gnt", spram_wren, 1);
    chk("burst_wr_rd_ready", rd_ready, 0);
    chk("burst_wr_addr", spram_addr, 14'h0050);
    tick();
    @(negedge clk);
    chk("burst_resume", rd_ready, 1);

    // Three back-to-back writes under read pressure
    tick();
    set_wr(1'b1, 14'h0060, 16'h1111);
    tick();
    set_wr(1'b1, 14'h0061, 16'h2222);
    tick();
    set_wr(1'b1, 14'h0062, 16'h3333);
    @(negedge clk);
    chk("bp_full", wr_ready, 0);
    chk("bp_rd", rd_ready, 1);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("bp_wr0", spram_wren, 1);
    chk("bp_wr0_data", spram_datain, 16'h1111);
    chk("bp_still_full", wr_ready, 0);
    tick();
    @(negedge clk);
    chk("bp_ready_again", wr_ready, 1);
    chk("bp_rd_again", rd_ready, 1);
    tick();
    set_wr(1'b0, 14'h0, 16'h0);
    rd_req = 1'b0;
    @(negedge clk);
    chk("bp_wr1_addr", spram_addr, 14'h0061);
    chk("bp_wr1_data", spram_datain, 16'h2222);
    tick();
    @(negedge clk);
    chk("bp_wr2_addr", spram_addr, 14'h0062);
    chk("bp_wr2_data", spram_datain, 16'h3333);
    tick();
    @(negedge clk);
    chk("bp_drained", spram_cs, 0);

    // Push and pop in the same cycle with one entry held
    set_wr(1'b1, 14'h0070, 16'hA1A1);
    tick();
    set_wr(1'b1, 14'h0071, 16'hB2B2);
    @(negedge clk);
    chk("pp_pop_old", spram_datain, 16'hA1A1);
    chk("pp_ready", wr_ready, 1);
    tick();
    set_wr(1'b0, 14'h0, 16'h0);
    @(negedge clk);
    chk("pp_occ_one", spram_wren, 1);
    chk("pp_pop_new", spram_datain, 16'hB2B2);
    tick();
    @(negedge clk);
    chk("pp_empty", spram_cs, 0);

    // Reset with two buffered writes and a read in flight
    rd_req  = 1'b1;
    rd_addr = 14'h0020;
    set_wr(1'b1, 14'h0080, 16'hDEAD);
    tick();
    set_wr(1'b1, 14'h0081, 16'hF00D);
    tick();
    set_wr(1'b0, 14'h0, 16'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_cs", spram_cs, 0);
    chk("mrst_rd_ready", rd_ready, 0);
    chk("mrst_wr_ready", wr_ready, 0);
    tick();
    reset  = 1'b0;
    rd_req = 1'b0;
    @(negedge clk);
    chk("mrst_rd_valid", rd_valid, 0);
    chk("mrst_wr_ready_after", wr_ready, 1);
    chk("mrst_discarded", spram_wren, 0);
    tick();
    @(negedge clk);
    chk("mrst_no_late_wr", spram_cs, 0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("mrst_read_ok", rd_data, 16'h1234);
    chk("mrst_read_valid", rd_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
